// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer.
// Provides op encodings, the sequencer state type and small op-decode helpers.
package muldiv_ctrl_pkg;

    // Op encodings presented by EX on muldiv_ctrl.op
    localparam logic [1:0] MULDIV_OP_MULT  = 2'b00;
    localparam logic [1:0] MULDIV_OP_MULTU = 2'b01;
    localparam logic [1:0] MULDIV_OP_DIV   = 2'b10;
    localparam logic [1:0] MULDIV_OP_DIVU  = 2'b11;

    // Sequencer state codes
    typedef enum logic [1:0] {
        MdIdle    = 2'b00,
        MdMulWait = 2'b01,
        MdDivBusy = 2'b10,
        MdDone    = 2'b11
    } md_state_e;

    // op[1] selects the divider, op[0] selects unsigned.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequences the shared multi-cycle multiplier and divider used by the EX stage.
// Latches one mult/multu/div/divu request, drives the external mul/div unit controls,
// stalls EX until the 2W-bit result is captured, then presents {hi,lo} until EX advances.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   flush                     kill the in-flight op (highest priority)
//   op_valid, op, src1, src2  request from EX
//   adv                       EX loads a new instruction at the next edge
//   mul_ina_o/inb_o/signed_o  multiplier operands, mul_result_i its product
//   div_opdata1_o/2_o, div_signed_o, div_start_o, div_annul_o  divider controls
//   div_ready_i, div_result_i divider handshake and {remainder, quotient}
//   stallreq_o                pipeline stall request
//   res_valid, hi_wdata, lo_wdata  HI/LO write data
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = 1,
    parameter int unsigned W       = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           op_valid,
    input  logic [1:0]     op,
    input  logic [W-1:0]   src1,
    input  logic [W-1:0]   src2,
    input  logic           adv,
    output logic [W-1:0]   mul_ina_o,
    output logic [W-1:0]   mul_inb_o,
    output logic           mul_signed_o,
    input  logic [2*W-1:0] mul_result_i,
    output logic [W-1:0]   div_opdata1_o,
    output logic [W-1:0]   div_opdata2_o,
    output logic           div_signed_o,
    output logic           div_start_o,
    output logic           div_annul_o,
    input  logic           div_ready_i,
    input  logic [2*W-1:0] div_result_i,
    output logic           stallreq_o,
    output logic           res_valid,
    output logic [W-1:0]   hi_wdata,
    output logic [W-1:0]   lo_wdata
);

    localparam int unsigned CntW = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);

    md_state_e   state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    src1_q, src1_d;
    logic [W-1:0]    src2_q, src2_d;
    logic [1:0]      op_q, op_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MdIdle;
            cnt_q   <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        src1_d        = src1_q;
        src2_d        = src2_q;
        op_d          = op_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        mul_ina_o     = '0;
        mul_inb_o     = '0;
        mul_signed_o  = 1'b0;
        div_opdata1_o = '0;
        div_opdata2_o = '0;
        div_signed_o  = 1'b0;
        div_start_o   = 1'b0;
        div_annul_o   = 1'b0;
        stallreq_o    = 1'b0;
        res_valid     = 1'b0;
        hi_wdata      = '0;
        lo_wdata      = '0;

        unique case (state_q)
            MdIdle: begin
                if (op_valid) begin
                    // Stall in the request cycle so EX holds the instruction.
                    stallreq_o = 1'b1;
                    src1_d     = src1;
                    src2_d     = src2;
                    op_d       = op;
                    if (op_is_div(op)) begin
                        state_d = MdDivBusy;
                    end else begin
                        state_d = MdMulWait;
                        cnt_d   = CntW'(MUL_LAT - 1);
                    end
                end
            end
            MdMulWait: begin
                stallreq_o   = 1'b1;
                mul_ina_o    = src1_q;
                mul_inb_o    = src2_q;
                mul_signed_o = op_is_signed(op_q);
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    hi_d    = mul_result_i[2*W-1:W];
                    lo_d    = mul_result_i[W-1:0];
                    state_d = MdDone;
                end
            end
            MdDivBusy: begin
                stallreq_o    = 1'b1;
                div_opdata1_o = src1_q;
                div_opdata2_o = src2_q;
                div_signed_o  = op_is_signed(op_q);
                if (div_ready_i) begin
                    // Start drops in the ready cycle so the divider is not relaunched.
                    hi_d    = div_result_i[2*W-1:W];
                    lo_d    = div_result_i[W-1:0];
                    state_d = MdDone;
                end else begin
                    div_start_o = 1'b1;
                end
            end
            MdDone: begin
                res_valid = 1'b1;
                hi_wdata  = hi_q;
                lo_wdata  = lo_q;
                if (adv) begin
                    state_d = MdIdle;
                end
            end
            default: state_d = MdIdle;
        endcase

        // Flush overrides everything: drop any launch or capture made above.
        if (flush) begin
            div_annul_o = (state_q == MdDivBusy);
            div_start_o = 1'b0;
            stallreq_o  = 1'b0;
            res_valid   = 1'b0;
            hi_wdata    = '0;
            lo_wdata    = '0;
            state_d     = MdIdle;
            cnt_d       = cnt_q;
            src1_d      = src1_q;
            src2_d      = src2_q;
            op_d        = op_q;
            hi_d        = hi_q;
            lo_d        = lo_q;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: behavioural mul/div units, scoreboard of expected
// {hi,lo} pushed at launch and popped when res_valid appears.
module tb_muldiv_ctrl;

    localparam int unsigned W       = 32;
    localparam int unsigned MUL_LAT = 1;
    localparam int unsigned DIV_CYC = 33;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          op_valid;
    logic [1:0]    op;
    logic [W-1:0]  src1;
    logic [W-1:0]  src2;
    logic          adv;
    logic [W-1:0]  mul_ina_o;
    logic [W-1:0]  mul_inb_o;
    logic          mul_signed_o;
    logic [63:0]   mul_result;
    logic [W-1:0]  div_opdata1_o;
    logic [W-1:0]  div_opdata2_o;
    logic          div_signed_o;
    logic          div_start_o;
    logic          div_annul_o;
    logic          div_ready;
    logic [63:0]   div_result;
    logic          stallreq_o;
    logic          res_valid;
    logic [W-1:0]  hi_wdata;
    logic [W-1:0]  lo_wdata;

    int n_chk;
    int n_fail;
    logic [63:0] sb[$];
    int div_cnt;

    muldiv_ctrl #(
        .MUL_LAT(MUL_LAT),
        .W      (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .op_valid     (op_valid),
        .op           (op),
        .src1         (src1),
        .src2         (src2),
        .adv          (adv),
        .mul_ina_o    (mul_ina_o),
        .mul_inb_o    (mul_inb_o),
        .mul_signed_o (mul_signed_o),
        .mul_result_i (mul_result),
        .div_opdata1_o(div_opdata1_o),
        .div_opdata2_o(div_opdata2_o),
        .div_signed_o (div_signed_o),
        .div_start_o  (div_start_o),
        .div_annul_o  (div_annul_o),
        .div_ready_i  (div_ready),
        .div_result_i (div_result),
        .stallreq_o   (stallreq_o),
        .res_valid    (res_valid),
        .hi_wdata     (hi_wdata),
        .lo_wdata     (lo_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic: {hi,lo} for each op.
    function automatic logic [63:0] exp_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] xa, xb;
        logic signed [31:0] sa, sbv;
        logic [31:0] q, r;
        sa  = a;
        sbv = b;
        case (o)
            2'b00: begin
                xa = {{32{a[31]}}, a};
                xb = {{32{b[31]}}, b};
                return xa * xb;
            end
            2'b01: begin
                xa = {32'b0, a};
                xb = {32'b0, b};
                return xa * xb;
            end
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sbv;
                r = sa % sbv;
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Multiplier with MUL_LAT=1: product valid in the cycle the operands are presented.
    always_comb mul_result = exp_result(mul_signed_o ? 2'b00 : 2'b01, mul_ina_o, mul_inb_o);

    // Divider: ready after DIV_CYC cycles of start; result from the presented operands.
    always_comb begin
        div_ready  = (div_cnt == DIV_CYC);
        div_result = exp_result(div_signed_o ? 2'b10 : 2'b11, div_opdata1_o, div_opdata2_o);
    end

    always_ff @(posedge clk) begin
        if (div_start_o && !div_annul_o) div_cnt <= div_cnt + 1;
        else                             div_cnt <= 0;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a request in the current (IDLE) cycle; returns sampled in the first busy cycle.
    task automatic launch(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        op_valid = 1'b1;
        op       = o;
        src1     = a;
        src2     = b;
        #1;
        check({tag, "_launch_stall"}, stallreq_o, 1);
        sb.push_back(exp_result(o, a, b));
        step();
        op_valid = 1'b0;
        op       = 2'($urandom);
        src1     = $urandom;
        src2     = $urandom;
        #1;
    endtask

    task automatic wait_done(input string tag, input int budget, output int n,
                             output int starts);
        logic [63:0] e;
        n      = 0;
        starts = 0;
        while (!res_valid && n < budget) begin
            if (div_ready) check({tag, "_start_drop"}, div_start_o, 0);
            check({tag, "_busy_stall"}, stallreq_o, 1);
            starts += int'(div_start_o);
            step();
            #1;
            n++;
        end
        if (!res_valid) begin
            check({tag, "_timeout"}, res_valid, 1);
        end else if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(sb.size()), 1);
        end else begin
            e = sb.pop_front();
            check({tag, "_hilo"}, {hi_wdata, lo_wdata}, e);
            check({tag, "_done_stall"}, stallreq_o, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, starts, hits;
        logic [63:0] e;
        n_chk    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        flush    = 1'b0;
        op_valid = 1'b0;
        op       = 2'b00;
        src1     = '0;
        src2     = '0;
        adv      = 1'b0;
        #12;
        check("reset_outs", {stallreq_o, res_valid, div_start_o, div_annul_o, mul_signed_o,
                             div_signed_o}, 0);
        check("reset_data", {hi_wdata, lo_wdata, mul_ina_o, div_opdata1_o}, 0);
        step();
        rst = 1'b0;
        step();

        // 1: multu 0xFFFFFFFF * 2
        launch("t1", 2'b01, 32'hFFFF_FFFF, 32'd2);
        check("t1_mul_ina", mul_ina_o, 32'hFFFF_FFFF);
        check("t1_mul_inb", mul_inb_o, 32'd2);
        check("t1_mul_signed", mul_signed_o, 0);
        check("t1_no_valid", res_valid, 0);
        wait_done("t1", 10, n, starts);
        check("t1_latency", n, 1);
        adv = 1'b1;
        step();
        adv = 1'b0;
        #1;
        check("t1_idle", {res_valid, stallreq_o}, 0);

        // 2: div -7 / 2
        launch("t2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        check("t2_div_signed", div_signed_o, 1);
        check("t2_div_op1", div_opdata1_o, 32'hFFFF_FFF9);
        wait_done("t2", 60, n, starts);
        check("t2_cycles", n, DIV_CYC + 1);
        check("t2_start_cycles", starts, DIV_CYC);
        check("t2_hilo_const", {hi_wdata, lo_wdata}, 64'hFFFF_FFFF_FFFF_FFFD);
        adv = 1'b1;
        step();
        adv = 1'b0;

        // 3: mult held in DONE with adv=0 for 3 cycles
        e = exp_result(2'b00, 32'h1234_5678, 32'hFFFF_FF00);
        launch("t3", 2'b00, 32'h1234_5678, 32'hFFFF_FF00);
        check("t3_mul_signed", mul_signed_o, 1);
        wait_done("t3", 10, n, starts);
        for (int i = 0; i < 2; i++) begin
            step();
            #1;
            check("t3_hold_valid", res_valid, 1);
            check("t3_hold_hilo", {hi_wdata, lo_wdata}, e);
            check("t3_hold_quiet", {stallreq_o, div_start_o}, 0);
        end
        adv = 1'b1;
        step();
        adv = 1'b0;
        #1;
        check("t3_idle", {res_valid, stallreq_o, div_start_o}, 0);

        // 4: flush 5 cycles into divu
        launch("t4", 2'b11, 32'd1000, 32'd3);
        for (int i = 0; i < 4; i++) step();
        flush = 1'b1;
        #1;
        check("t4_annul", div_annul_o, 1);
        check("t4_flush_quiet", {div_start_o, stallreq_o, res_valid}, 0);
        void'(sb.pop_back());
        step();
        flush = 1'b0;
        #1;
        check("t4_after_flush", {div_annul_o, div_start_o, stallreq_o}, 0);
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            hits += int'(res_valid);
            step();
        end
        check("t4_never_valid", hits, 0);

        // flush together with op_valid in IDLE: no launch
        flush    = 1'b1;
        op_valid = 1'b1;
        op       = 2'b10;
        src1     = 32'd9;
        src2     = 32'd3;
        #1;
        check("fo_no_stall", stallreq_o, 0);
        step();
        flush    = 1'b0;
        op_valid = 1'b0;
        #1;
        check("fo_still_idle", {stallreq_o, div_start_o, res_valid}, 0);

        // 5: async reset mid DIV_BUSY
        launch("t5", 2'b10, 32'd50, 32'd5);
        step();
        step();
        #3;
        rst = 1'b1;
        #1;
        check("t5_rst_ctrl", {stallreq_o, div_start_o, res_valid, div_signed_o}, 0);
        check("t5_rst_data", {div_opdata1_o, div_opdata2_o, hi_wdata, lo_wdata}, 0);
        void'(sb.pop_back());
        step();
        rst = 1'b0;
        step();
        launch("t5m", 2'b00, 32'hFFFF_FFFD, 32'd7);
        wait_done("t5m", 10, n, starts);
        check("t5m_latency", n, 1);
        adv = 1'b1;

        // 6: back-to-back mult then divu; second op launches right after DONE
        step();
        adv = 1'b0;
        launch("t6a", 2'b00, 32'd6, 32'd7);
        wait_done("t6a", 10, n, starts);
        adv = 1'b1;
        step();
        adv = 1'b0;
        launch("t6b", 2'b11, 32'd100, 32'd7);
        check("t6b_op1", div_opdata1_o, 32'd100);
        check("t6b_op2", div_opdata2_o, 32'd7);
        check("t6b_unsigned", div_signed_o, 0);
        wait_done("t6b", 60, n, starts);
        adv = 1'b1;
        step();
        adv = 1'b0;
        #1;
        check("t6_idle", {res_valid, stallreq_o}, 0);
        check("sb_drained", 64'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
